// File: rtl/cell_nand_pkg.sv
// Elaboration-time helpers for the pipelined NAND reduction: tree depth,
// stage count and per-level operand counts.
package cell_nand_pkg;

  function automatic int tree_depth(input int n);
    int d;
    int w;
    d = 0;
    w = 1;
    while (w < n) begin
      w = w * 2;
      d++;
    end
    return d;
  endfunction

  function automatic int stage_count(input int d, input int lps);
    if (d <= 0) return 1;
    return (d + lps - 1) / lps;
  endfunction

  function automatic int level_width(input int n, input int lvl);
    int w;
    w = n;
    for (int i = 0; i < lvl; i++) w = (w + 1) / 2;
    return w;
  endfunction

endpackage

// File: rtl/cell_nand_reduce_stage.sv
// One pipeline stage: LEVELS pairwise-AND levels per channel, optional final
// inversion, then a valid/data register with a local ready term.
module cell_nand_reduce_stage
  import cell_nand_pkg::*;
#(
  parameter int CH     = 1,
  parameter int W      = 8,
  parameter int LEVELS = 1,
  parameter int W_OUT  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CH*W-1:0]   up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CH*W_OUT-1:0] dn_data
);

  localparam int W_RES = level_width(W, LEVELS);

  if (W_OUT < W_RES) begin : g_width_check
    $error("cell_nand_reduce_stage: W_OUT too narrow for the reduced operands");
  end

  logic                 v_q, v_d;
  logic [CH*W_OUT-1:0]  data_q, data_d;
  logic [CH*W_OUT-1:0]  tree_out;

  assign up_ready = ~v_q | dn_ready;
  assign dn_valid = v_q;
  assign dn_data  = data_q;

  // Operands sit in the low bits of a vector whose upper half is all ones, so
  // unpaired operands are ANDed with the identity and unused slots stay 1.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    logic [2*W-1:0] pad;
    always_comb begin
      pad = {{W{1'b1}}, up_data[gi*W +: W]};
      for (int l = 0; l < LEVELS; l++) begin
        for (int i = 0; i < W; i++) begin
          pad[i] = pad[2*i] & pad[2*i+1];
        end
      end
    end
    if (INVERT) begin : g_inv
      assign tree_out[gi*W_OUT +: W_OUT] = ~pad[W_OUT-1:0];
    end else begin : g_pass
      assign tree_out[gi*W_OUT +: W_OUT] = pad[W_OUT-1:0];
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (up_ready) begin
      v_d = up_valid;
      if (up_valid) data_d = tree_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/cell_nand_reduce_pipe.sv
// CHANNELS-lane pipelined NAND reduction with valid/ready flow control.
// Define CELL_NAND_REDUCE_STATS_EN to add the saturating zero_cnt statistic.
module cell_nand_reduce_pipe
  import cell_nand_pkg::*;
#(
  parameter int INPUTS           = 8,
  parameter int CHANNELS         = 1,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int CNT_W            = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*INPUTS-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS-1:0]          out_data
`ifdef CELL_NAND_REDUCE_STATS_EN
  ,
  output logic [CNT_W-1:0]             zero_cnt
`endif
);

  localparam int D = tree_depth(INPUTS);
  localparam int S = stage_count(D, LEVELS_PER_STAGE);

  if (INPUTS < 2) begin : g_err_inputs
    $error("cell_nand_reduce_pipe: INPUTS must be >= 2");
  end
  if (CHANNELS < 1) begin : g_err_channels
    $error("cell_nand_reduce_pipe: CHANNELS must be >= 1");
  end
  if (LEVELS_PER_STAGE < 1) begin : g_err_lps
    $error("cell_nand_reduce_pipe: LEVELS_PER_STAGE must be >= 1");
  end

  logic                       rdy [S+1];
  logic                       vld [S+1];
  logic [CHANNELS*INPUTS-1:0] bus [S];

  assign vld[0]    = in_valid;
  assign bus[0]    = in_data;
  assign rdy[S]    = out_ready;
  assign in_ready  = rdy[0];
  assign out_valid = vld[S];

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    // The last stage may hold fewer tree levels than the others.
    localparam int LV = ((D - gi*LEVELS_PER_STAGE) < LEVELS_PER_STAGE)
                        ? (D - gi*LEVELS_PER_STAGE) : LEVELS_PER_STAGE;
    if (gi == S-1) begin : g_last
      cell_nand_reduce_stage #(
        .CH(CHANNELS), .W(INPUTS), .LEVELS(LV), .W_OUT(1), .INVERT(1'b1)
      ) u_stage (
        .clk(clk), .rst(rst),
        .up_valid(vld[gi]), .up_ready(rdy[gi]), .up_data(bus[gi]),
        .dn_valid(vld[gi+1]), .dn_ready(rdy[gi+1]), .dn_data(out_data)
      );
    end else begin : g_mid
      cell_nand_reduce_stage #(
        .CH(CHANNELS), .W(INPUTS), .LEVELS(LV), .W_OUT(INPUTS), .INVERT(1'b0)
      ) u_stage (
        .clk(clk), .rst(rst),
        .up_valid(vld[gi]), .up_ready(rdy[gi]), .up_data(bus[gi]),
        .dn_valid(vld[gi+1]), .dn_ready(rdy[gi+1]), .dn_data(bus[gi+1])
      );
    end
  end

`ifdef CELL_NAND_REDUCE_STATS_EN
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (out_valid && out_ready && !(&out_data) && (zero_cnt_q != {CNT_W{1'b1}})) begin
      zero_cnt_d = zero_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) zero_cnt_q <= '0;
    else     zero_cnt_q <= zero_cnt_d;
  end

  assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_cell_nand_reduce_pipe.sv
// Randomised self-checking bench: an 8x2 two-stage instance and a 5x1
// three-stage instance, checked against a per-channel all-ones model.
module tb_cell_nand_reduce_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: INPUTS=8, CHANNELS=2, LPS=2 -> S=2
  logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
  logic [15:0] in_data_a  = '0;
  logic [1:0]  out_data_a;
  // Instance B: INPUTS=5, CHANNELS=1, LPS=1 -> S=3
  logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [4:0]  in_data_b  = '0;
  logic [0:0]  out_data_b;
`ifdef CELL_NAND_REDUCE_STATS_EN
  logic [1:0]  zero_cnt_a;
  logic [1:0]  zero_cnt_b;
`endif

  cell_nand_reduce_pipe #(.INPUTS(8), .CHANNELS(2), .LEVELS_PER_STAGE(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a)
`ifdef CELL_NAND_REDUCE_STATS_EN
    , .zero_cnt(zero_cnt_a)
`endif
  );

  cell_nand_reduce_pipe #(.INPUTS(5), .CHANNELS(1), .LEVELS_PER_STAGE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
`ifdef CELL_NAND_REDUCE_STATS_EN
    , .zero_cnt(zero_cnt_b)
`endif
  );

  int tests  = 0;
  int failed = 0;

  logic        acc_a, ox_a, acc_b, ox_b;
  logic [15:0] ad_a;
  logic [1:0]  od_a;
  logic [0:0]  od_b;
  logic [1:0]  exp_q [$];

  // Reference: a channel's NAND is 0 exactly when every operand is 1.
  function automatic logic [1:0] model_a(input logic [15:0] d);
    logic [1:0] r;
    for (int c = 0; c < 2; c++) r[c] = (((d >> (c*8)) & 16'h00FF) == 16'h00FF) ? 1'b0 : 1'b1;
    return r;
  endfunction

  // Records the transfers that happen at the coming rising edge (no checking).
  task automatic tick();
    @(negedge clk);
    acc_a = in_valid_a & in_ready_a;
    ad_a  = in_data_a;
    ox_a  = out_valid_a & out_ready_a;
    od_a  = out_data_a;
    acc_b = in_valid_b & in_ready_b;
    ox_b  = out_valid_b & out_ready_b;
    od_b  = out_data_b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (out_valid_a !== 1'b0) begin failed++; $display("FAIL rst_out_valid got=%b want=0", out_valid_a); end
    tests++; if (in_ready_a !== 1'b1) begin failed++; $display("FAIL rst_in_ready got=%b want=1", in_ready_a); end
    tests++; if (out_data_a !== 2'b00) begin failed++; $display("FAIL rst_out_data got=%b want=00", out_data_a); end
    tests++; if (out_valid_b !== 1'b0) begin failed++; $display("FAIL rst_out_valid_b got=%b want=0", out_valid_b); end
`ifdef CELL_NAND_REDUCE_STATS_EN
    tests++; if (zero_cnt_a !== 2'd0) begin failed++; $display("FAIL rst_zero_cnt got=%0d want=0", zero_cnt_a); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (in_ready_a !== 1'b1) begin failed++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready_a); end
    $display("[TB] reset checked");
  endtask

  task automatic test_latency(input logic [15:0] d, input logic [1:0] want);
    int lat;
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1;
    in_data_a   = d;
    tick();
    in_valid_a = 1'b0;
    tests++; if (acc_a !== 1'b1) begin failed++; $display("FAIL lat_accept got=%b want=1", acc_a); end
    lat = 1;
    while (out_valid_a !== 1'b1 && lat < 20) begin tick(); lat++; end
    tests++; if (lat != 2) begin failed++; $display("FAIL lat_cycles got=%0d want=2", lat); end
    tests++; if (out_data_a !== want) begin failed++; $display("FAIL lat_data in=%h got=%b want=%b", d, out_data_a, want); end
    tick();
    $display("[TB] latency in=%h out=%b lat=%0d", d, out_data_a, lat);
  endtask

  task automatic test_back_to_back();
    int n_in = 0, n_out = 0, bubbles = 0, stalls = 0, cyc = 0;
    logic [1:0] e;
    exp_q.delete();
    out_ready_a = 1'b1;
    while (n_out < 100 && cyc < 400) begin
      in_valid_a = (n_in < 100);
      // Bias some beats towards all-ones channels so both outcomes occur.
      in_data_a  = $urandom;
      if ($urandom_range(0, 3) == 0) in_data_a[7:0]  = 8'hFF;
      if ($urandom_range(0, 3) == 0) in_data_a[15:8] = 8'hFF;
      tick();
      cyc++;
      if (in_valid_a && !acc_a) stalls++;
      if (acc_a) begin exp_q.push_back(model_a(ad_a)); n_in++; end
      if (n_out > 0 && n_out < 100 && !ox_a) bubbles++;
      if (ox_a) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++; $display("FAIL stream_extra got=%b want=none", od_a);
        end else begin
          e = exp_q.pop_front();
          if (od_a !== e) begin failed++; $display("FAIL stream_data idx=%0d got=%b want=%b", n_out, od_a, e); end
        end
        n_out++;
      end
    end
    in_valid_a = 1'b0;
    tests++; if (n_out != 100) begin failed++; $display("FAIL stream_count got=%0d want=100", n_out); end
    tests++; if (bubbles != 0) begin failed++; $display("FAIL stream_bubbles got=%0d want=0", bubbles); end
    tests++; if (stalls != 0) begin failed++; $display("FAIL stream_in_stalls got=%0d want=0", stalls); end
    $display("[TB] stream outputs=%0d bubbles=%0d", n_out, bubbles);
  endtask

  task automatic test_backpressure();
    int accepted = 0, drained = 0, changes = 0;
    logic       have_ref = 1'b0;
    logic [1:0] ref_d = '0, e;
    exp_q.delete();
    out_ready_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = (i == 0) ? 16'hFFFF : 16'($urandom);
      tick();
      if (acc_a) begin exp_q.push_back(model_a(ad_a)); accepted++; end
      if (out_valid_a) begin
        if (!have_ref) begin ref_d = out_data_a; have_ref = 1'b1; end
        else if (out_data_a !== ref_d) changes++;
      end
    end
    tests++; if (accepted != 2) begin failed++; $display("FAIL bp_accepts got=%0d want=2", accepted); end
    tests++; if (in_ready_a !== 1'b0) begin failed++; $display("FAIL bp_in_ready got=%b want=0", in_ready_a); end
    tests++; if (!have_ref || changes != 0) begin failed++; $display("FAIL bp_stable got_changes=%0d seen=%b want=0", changes, have_ref); end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ox_a) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++; $display("FAIL bp_dup got=%b want=none", od_a);
        end else begin
          e = exp_q.pop_front();
          if (od_a !== e) begin failed++; $display("FAIL bp_drain_data got=%b want=%b", od_a, e); end
        end
        drained++;
      end
    end
    tests++; if (drained != 2) begin failed++; $display("FAIL bp_drained got=%0d want=2", drained); end
    $display("[TB] backpressure accepted=%0d drained=%0d", accepted, drained);
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 16'hFFFF;
      tick();
    end
    in_valid_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (out_valid_a !== 1'b0) begin failed++; $display("FAIL midrst_out_valid got=%b want=0", out_valid_a); end
    tests++; if (in_ready_a !== 1'b1) begin failed++; $display("FAIL midrst_in_ready got=%b want=1", in_ready_a); end
    tests++; if (out_data_a !== 2'b00) begin failed++; $display("FAIL midrst_out_data got=%b want=00", out_data_a); end
    out_ready_a = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (ox_a) stale++; end
    tests++; if (stale != 0) begin failed++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    $display("[TB] mid-operation reset stale=%0d", stale);
  endtask

  task automatic test_odd_operands();
    logic [4:0] pats [8];
    logic [0:0] want;
    int lat;
    pats[0] = 5'b11111; pats[1] = 5'b01111; pats[2] = 5'b10111; pats[3] = 5'b11011;
    pats[4] = 5'b11101; pats[5] = 5'b11110; pats[6] = 5'b00000; pats[7] = 5'($urandom);
    out_ready_b = 1'b1;
    for (int p = 0; p < 8; p++) begin
      want       = (pats[p] == 5'b11111) ? 1'b0 : 1'b1;
      in_valid_b = 1'b1;
      in_data_b  = pats[p];
      tick();
      in_valid_b = 1'b0;
      lat = 1;
      while (out_valid_b !== 1'b1 && lat < 20) begin tick(); lat++; end
      tests++; if (lat != 3) begin failed++; $display("FAIL odd_latency in=%b got=%0d want=3", pats[p], lat); end
      tests++; if (out_data_b !== want) begin failed++; $display("FAIL odd_data in=%b got=%b want=%b", pats[p], out_data_b, want); end
      tick();
      $display("[TB] odd in=%b out=%b lat=%0d", pats[p], out_data_b, lat);
    end
  endtask

`ifdef CELL_NAND_REDUCE_STATS_EN
  task automatic test_stats();
    int k = 0, n_in = 0, cyc = 0, want;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_data_a   = 16'hFFFF;
    tick();
    in_valid_a = 1'b0;
    repeat (4) tick();
    tests++; if (zero_cnt_a !== 2'd0 || out_valid_a !== 1'b1) begin
      failed++; $display("FAIL stats_stalled got=%0d valid=%b want=0 valid=1", zero_cnt_a, out_valid_a);
    end
    out_ready_a = 1'b1;
    while (k < 5 && cyc < 40) begin
      in_valid_a = (n_in < 4);
      in_data_a  = n_in[0] ? 16'h00FF : 16'hFF3C;
      tick();
      cyc++;
      if (acc_a) n_in++;
      if (ox_a) begin
        k++;
        want = (k > 3) ? 3 : k;
        tests++; if (zero_cnt_a !== 2'(want)) begin failed++; $display("FAIL stats_cnt beat=%0d got=%0d want=%0d", k, zero_cnt_a, want); end
        $display("[TB] stats beat=%0d zero_cnt=%0d", k, zero_cnt_a);
      end
    end
    in_valid_a = 1'b0;
    tests++; if (k != 5) begin failed++; $display("FAIL stats_beats got=%0d want=5", k); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency(16'hFFFF, 2'b00);
    test_latency(16'h7FFF, 2'b10);
    test_latency(16'hFF7F, 2'b01);
    test_latency(16'h1234, 2'b11);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_odd_operands();
`ifdef CELL_NAND_REDUCE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
